// File: rtl/s_xdiv_pe.sv
// s_xdiv_pe: streaming divider PE that picks two operands from neighbour streams,
// runs a one-bit-per-cycle restoring divider and feeds a programmable-length delay line.
module s_xdiv_pe #(
  parameter int N_BITS      = 32,
  parameter int N_SRC       = 4,
  parameter int DELAY_DEPTH = 4,
  localparam int SEL_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int LEN_W      = $clog2(DELAY_DEPTH) + 1,
  localparam int CNT_W      = $clog2(N_BITS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2:0]              op_i,
  input  logic [SEL_W-1:0]        sel_a_i,
  input  logic [SEL_W-1:0]        sel_b_i,
  input  logic [1:0]              delay_sel_i,
  input  logic [LEN_W-1:0]        delay_len_i,
  input  logic [N_SRC*N_BITS-1:0] src_i,
  input  logic [N_SRC-1:0]        src_valid_i,
  input  logic                    pea_ready_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [N_BITS-1:0]       pe_res_o,
  output logic [N_BITS-1:0]       rem_q_o,
  output logic [N_BITS-1:0]       delay_op_o,
  output logic                    delay_op_valid_o
);

  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_REM  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [N_BITS-1:0]  w_src [N_SRC];
  logic [N_BITS-1:0]  w_op_a;
  logic [N_BITS-1:0]  w_op_b;
  logic               w_ops_valid;
  logic               w_op_legal;
  logic               w_is_signed;
  logic               w_is_rem;
  logic               w_div_zero;
  logic               w_accept;
  logic               w_step;
  logic               w_last;

  logic               r_is_rem;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [N_BITS-1:0]  r_quot;
  logic [N_BITS-1:0]  r_rem;
  logic [N_BITS-1:0]  r_div;
  logic [CNT_W-1:0]   r_count;
  logic [N_BITS-1:0]  r_res;
  logic [N_BITS-1:0]  r_rq;
  logic               r_valid;

  logic [N_BITS:0]    w_shift;
  logic [N_BITS:0]    w_trial;
  logic               w_borrow;
  logic [N_BITS-1:0]  w_rem_nxt;
  logic [N_BITS-1:0]  w_quot_nxt;
  logic [N_BITS-1:0]  w_q_fix;
  logic [N_BITS-1:0]  w_r_fix;

  logic [N_BITS-1:0]  r_dly_data [DELAY_DEPTH];
  logic               r_dly_vld  [DELAY_DEPTH];
  logic [N_BITS-1:0]  w_dly_in;
  logic               w_dly_in_vld;
  logic [LEN_W-1:0]   w_tap;
  logic [N_BITS-1:0]  w_tap_data;
  logic               w_tap_vld;

  function automatic logic [N_BITS-1:0] f_neg(input logic [N_BITS-1:0] v);
    f_neg = ~v + N_BITS'(1);
  endfunction

  function automatic logic [N_BITS-1:0] f_mag(input logic [N_BITS-1:0] v, input logic is_signed);
    f_mag = (is_signed && v[N_BITS-1]) ? f_neg(v) : v;
  endfunction

  // Unpack the flat neighbour bus into one word per source.
  always_comb begin
    for (int k = 0; k < N_SRC; k++) begin
      w_src[k] = src_i[k*N_BITS +: N_BITS];
    end
  end

  // Operand selection and divisor-zero detection.
  always_comb begin
    w_op_a      = w_src[sel_a_i];
    w_op_b      = w_src[sel_b_i];
    w_ops_valid = src_valid_i[sel_a_i] & src_valid_i[sel_b_i];
    w_div_zero  = (w_op_b == '0);
  end

  // Opcode decode; anything outside 1..4 is treated as NOP.
  always_comb begin
    w_op_legal  = 1'b0;
    w_is_signed = 1'b0;
    w_is_rem    = 1'b0;
    case (op_i)
      OP_DIV:  begin w_op_legal = 1'b1; w_is_signed = 1'b1; w_is_rem = 1'b0; end
      OP_REM:  begin w_op_legal = 1'b1; w_is_signed = 1'b1; w_is_rem = 1'b1; end
      OP_DIVU: begin w_op_legal = 1'b1; w_is_signed = 1'b0; w_is_rem = 1'b0; end
      OP_REMU: begin w_op_legal = 1'b1; w_is_signed = 1'b0; w_is_rem = 1'b1; end
      default: begin w_op_legal = 1'b0; w_is_signed = 1'b0; w_is_rem = 1'b0; end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; a NOP/illegal opcode overrides everything and returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_op_legal) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_nxt = w_div_zero ? S_DONE : S_CALC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_CALC: begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_CALC;
          end
        end
        S_DONE: begin
          if (pea_ready_i) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath strobes.
  always_comb begin
    ready_o  = (r_state == S_IDLE);
    w_accept = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      S_IDLE:  begin w_accept = w_op_legal & w_ops_valid; w_step = 1'b0; end
      S_CALC:  begin w_accept = 1'b0; w_step = w_op_legal; end
      S_DONE:  begin w_accept = 1'b0; w_step = 1'b0; end
      default: begin w_accept = 1'b0; w_step = 1'b0; end
    endcase
    w_last = w_step & (r_count == CNT_W'(N_BITS - 1));
  end

  // One restoring step: r_quot shifts the dividend out at the top while quotient bits enter below.
  always_comb begin
    w_shift    = {r_rem, r_quot[N_BITS-1]};
    w_trial    = w_shift - {1'b0, r_div};
    w_borrow   = w_trial[N_BITS];
    w_rem_nxt  = w_borrow ? w_shift[N_BITS-1:0] : w_trial[N_BITS-1:0];
    w_quot_nxt = {r_quot[N_BITS-2:0], ~w_borrow};
    w_q_fix    = r_neg_q ? f_neg(w_quot_nxt) : w_quot_nxt;
    w_r_fix    = r_neg_r ? f_neg(w_rem_nxt) : w_rem_nxt;
  end

  // Divider datapath and registered results.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_count  <= '0;
      r_res    <= '0;
      r_rq     <= '0;
      r_valid  <= 1'b0;
    end else if (!w_op_legal) begin
      r_res   <= '0;
      r_rq    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_is_rem <= w_is_rem;
        r_neg_q  <= w_is_signed & (w_op_a[N_BITS-1] ^ w_op_b[N_BITS-1]);
        r_neg_r  <= w_is_signed & w_op_a[N_BITS-1];
        r_quot   <= f_mag(w_op_a, w_is_signed);
        r_div    <= f_mag(w_op_b, w_is_signed);
        r_rem    <= '0;
        r_count  <= '0;
        if (w_div_zero) begin
          r_res <= w_is_rem ? w_op_a : '1;
          r_rq  <= w_is_rem ? '1 : w_op_a;
        end
      end else if (w_step) begin
        r_rem   <= w_rem_nxt;
        r_quot  <= w_quot_nxt;
        r_count <= r_count + CNT_W'(1);
        if (w_last) begin
          r_res <= r_is_rem ? w_r_fix : w_q_fix;
          r_rq  <= r_is_rem ? w_q_fix : w_r_fix;
        end
      end
    end
  end

  assign valid_o  = r_valid;
  assign pe_res_o = r_res;
  assign rem_q_o  = r_rq;

  // Delay-line input source select.
  always_comb begin
    w_dly_in     = '0;
    w_dly_in_vld = 1'b0;
    case (delay_sel_i)
      2'd0:    begin w_dly_in = w_op_a;   w_dly_in_vld = src_valid_i[sel_a_i]; end
      2'd1:    begin w_dly_in = w_op_b;   w_dly_in_vld = src_valid_i[sel_b_i]; end
      2'd2:    begin w_dly_in = r_rq;     w_dly_in_vld = r_valid; end
      2'd3:    begin w_dly_in = w_src[0]; w_dly_in_vld = src_valid_i[0]; end
      default: begin w_dly_in = '0;       w_dly_in_vld = 1'b0; end
    endcase
  end

  // Delay line advances only with the array-wide ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DELAY_DEPTH; k++) begin
        r_dly_data[k] <= '0;
        r_dly_vld[k]  <= 1'b0;
      end
    end else if (pea_ready_i) begin
      r_dly_data[0] <= w_dly_in;
      r_dly_vld[0]  <= w_dly_in_vld;
      for (int k = 1; k < DELAY_DEPTH; k++) begin
        r_dly_data[k] <= r_dly_data[k-1];
        r_dly_vld[k]  <= r_dly_vld[k-1];
      end
    end
  end

  // Tap index: length 0 acts as 1, lengths past the end clamp to the last stage.
  always_comb begin
    w_tap = '0;
    if (delay_len_i == '0) begin
      w_tap = '0;
    end else if (delay_len_i > LEN_W'(DELAY_DEPTH)) begin
      w_tap = LEN_W'(DELAY_DEPTH - 1);
    end else begin
      w_tap = delay_len_i - LEN_W'(1);
    end
  end

  // Tap mux over the stage registers; retaps without flushing.
  always_comb begin
    w_tap_data = r_dly_data[0];
    w_tap_vld  = r_dly_vld[0];
    for (int k = 0; k < DELAY_DEPTH; k++) begin
      w_tap_data = (w_tap == LEN_W'(k)) ? r_dly_data[k] : w_tap_data;
      w_tap_vld  = (w_tap == LEN_W'(k)) ? r_dly_vld[k]  : w_tap_vld;
    end
  end

  assign delay_op_o       = w_tap_data;
  assign delay_op_valid_o = w_tap_vld;

endmodule

// File: tb/tb_s_xdiv_pe.sv
// Directed self-checking bench for s_xdiv_pe (N_BITS=32, N_SRC=4, DELAY_DEPTH=4).
module tb_s_xdiv_pe;
  localparam int NB = 32;
  localparam int NS = 4;
  localparam int DD = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [2:0]    op_i;
  logic [1:0]    sel_a_i;
  logic [1:0]    sel_b_i;
  logic [1:0]    delay_sel_i;
  logic [2:0]    delay_len_i;
  logic [127:0]  src_i;
  logic [3:0]    src_valid_i;
  logic          pea_ready_i;
  logic          ready_o;
  logic          valid_o;
  logic [31:0]   pe_res_o;
  logic [31:0]   rem_q_o;
  logic [31:0]   delay_op_o;
  logic          delay_op_valid_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  s_xdiv_pe #(.N_BITS(NB), .N_SRC(NS), .DELAY_DEPTH(DD)) dut (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .sel_a_i(sel_a_i), .sel_b_i(sel_b_i),
    .delay_sel_i(delay_sel_i), .delay_len_i(delay_len_i), .src_i(src_i),
    .src_valid_i(src_valid_i), .pea_ready_i(pea_ready_i), .ready_o(ready_o),
    .valid_o(valid_o), .pe_res_o(pe_res_o), .rem_q_o(rem_q_o),
    .delay_op_o(delay_op_o), .delay_op_valid_o(delay_op_valid_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1; op_i = 3'd0; src_i = '0; src_valid_i = 4'b0000;
    sel_a_i = 2'd0; sel_b_i = 2'd1; delay_sel_i = 2'd0; delay_len_i = 3'd1; pea_ready_i = 1'b1;
    tick;
    rst_i = 1'b0;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    src_i[31:0] = a; src_i[63:32] = b; src_valid_i = 4'b0011;
    sel_a_i = 2'd0; sel_b_i = 2'd1; op_i = op;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick;
      if (valid_o === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    delay_len_i = 3'd4;
    rst_i = 1'b1; op_i = 3'd0; src_i = '0; src_valid_i = 4'b0000;
    sel_a_i = 2'd0; sel_b_i = 2'd1; delay_sel_i = 2'd0; pea_ready_i = 1'b1;
    tick;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%h exp=1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", valid_o); end
    checks++; if (pe_res_o !== 32'd0) begin failures++; $display("FAIL reset_res got=%h exp=0", pe_res_o); end
    checks++; if (rem_q_o !== 32'd0) begin failures++; $display("FAIL reset_rq got=%h exp=0", rem_q_o); end
    checks++; if (delay_op_o !== 32'd0 || delay_op_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_delay got=%h/%h exp=0/0", delay_op_o, delay_op_valid_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_div_timing;
    do_reset;
    launch(3'd1, 32'd100, 32'd7);
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL div_ready_c0 got=%h exp=1", ready_o); end
    for (int c = 1; c <= 34; c++) begin
      tick;
      checks++;
      if (ready_o !== ((c <= 33) ? 1'b0 : 1'b1)) begin
        failures++; $display("FAIL div_ready cycle=%0d got=%h", c, ready_o); end
      checks++;
      if (valid_o !== (c == 33)) begin
        failures++; $display("FAIL div_valid cycle=%0d got=%h", c, valid_o); end
      if (c == 33) begin
        checks++; if (pe_res_o !== 32'd14) begin failures++; $display("FAIL div_q got=%h exp=0000000e", pe_res_o); end
        checks++; if (rem_q_o !== 32'd2) begin failures++; $display("FAIL div_r got=%h exp=00000002", rem_q_o); end
      end
    end
  endtask

  task automatic test_signed_rem;
    int n;
    do_reset;
    launch(3'd2, 32'hFFFFFF9C, 32'd7);
    wait_valid(n);
    checks++; if (n != 33) begin failures++; $display("FAIL rem_latency got=%0d exp=33", n); end
    checks++; if (pe_res_o !== 32'hFFFFFFFE) begin failures++; $display("FAIL rem_res got=%h exp=fffffffe", pe_res_o); end
    checks++; if (rem_q_o !== 32'hFFFFFFF2) begin failures++; $display("FAIL rem_q got=%h exp=fffffff2", rem_q_o); end
  endtask

  task automatic test_divu;
    int n;
    do_reset;
    launch(3'd3, 32'hFFFFFFFF, 32'd2);
    wait_valid(n);
    checks++; if (n != 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", n); end
    checks++; if (pe_res_o !== 32'h7FFFFFFF) begin failures++; $display("FAIL divu_q got=%h exp=7fffffff", pe_res_o); end
    checks++; if (rem_q_o !== 32'd1) begin failures++; $display("FAIL divu_r got=%h exp=00000001", rem_q_o); end
  endtask

  task automatic test_div_zero;
    int n;
    do_reset;
    delay_sel_i = 2'd2; delay_len_i = 3'd1;
    launch(3'd1, 32'd5, 32'd0);
    wait_valid(n);
    checks++; if (n != 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", n); end
    checks++; if (pe_res_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_q got=%h exp=ffffffff", pe_res_o); end
    checks++; if (rem_q_o !== 32'd5) begin failures++; $display("FAIL dz_r got=%h exp=00000005", rem_q_o); end
    tick;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++; $display("FAIL dz_idle got=%h/%h exp=0/1", valid_o, ready_o); end
    checks++; if (pe_res_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_hold got=%h exp=ffffffff", pe_res_o); end
    checks++; if (delay_op_o !== 32'd5 || delay_op_valid_o !== 1'b1) begin
      failures++; $display("FAIL dz_delay_remq got=%h/%h exp=5/1", delay_op_o, delay_op_valid_o); end
    do_reset;
    launch(3'd4, 32'd9, 32'd0);
    wait_valid(n);
    checks++; if (n != 1) begin failures++; $display("FAIL dzu_latency got=%0d exp=1", n); end
    checks++; if (pe_res_o !== 32'd9) begin failures++; $display("FAIL dzu_res got=%h exp=00000009", pe_res_o); end
    checks++; if (rem_q_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL dzu_q got=%h exp=ffffffff", rem_q_o); end
  endtask

  task automatic test_overflow;
    int n;
    do_reset;
    launch(3'd1, 32'h80000000, 32'hFFFFFFFF);
    wait_valid(n);
    checks++; if (n != 33) begin failures++; $display("FAIL ovf_latency got=%0d exp=33", n); end
    checks++; if (pe_res_o !== 32'h80000000) begin failures++; $display("FAIL ovf_q got=%h exp=80000000", pe_res_o); end
    checks++; if (rem_q_o !== 32'd0) begin failures++; $display("FAIL ovf_r got=%h exp=00000000", rem_q_o); end
  endtask

  task automatic test_backpressure;
    int n;
    do_reset;
    delay_sel_i = 2'd3; delay_len_i = 3'd1;
    launch(3'd1, 32'd100, 32'd7);
    wait_valid(n);
    checks++; if (n != 33) begin failures++; $display("FAIL bp_latency got=%0d exp=33", n); end
    pea_ready_i = 1'b0; src_valid_i = 4'b0000; src_i[31:0] = 32'h55;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
        failures++; $display("FAIL bp_hold_flags step=%0d got=%h/%h exp=1/0", c, valid_o, ready_o); end
      checks++; if (pe_res_o !== 32'd14 || rem_q_o !== 32'd2) begin
        failures++; $display("FAIL bp_hold_data step=%0d got=%h/%h exp=e/2", c, pe_res_o, rem_q_o); end
      checks++; if (delay_op_o !== 32'd100 || delay_op_valid_o !== 1'b1) begin
        failures++; $display("FAIL bp_delay_frozen step=%0d got=%h/%h exp=64/1", c, delay_op_o, delay_op_valid_o); end
    end
    pea_ready_i = 1'b1;
    tick;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      failures++; $display("FAIL bp_release got=%h/%h exp=1/0", ready_o, valid_o); end
    checks++; if (pe_res_o !== 32'd14) begin failures++; $display("FAIL bp_res_hold got=%h exp=e", pe_res_o); end
    checks++; if (delay_op_o !== 32'h55 || delay_op_valid_o !== 1'b0) begin
      failures++; $display("FAIL bp_delay_shift got=%h/%h exp=55/0", delay_op_o, delay_op_valid_o); end
  endtask

  task automatic test_back_to_back;
    int n;
    do_reset;
    launch(3'd1, 32'd100, 32'd7);
    wait_valid(n);
    checks++; if (n != 33 || pe_res_o !== 32'd14) begin
      failures++; $display("FAIL b2b_first got=%0d/%h exp=33/e", n, pe_res_o); end
    src_i[31:0] = 32'd50; src_i[63:32] = 32'hFFFFFFFD;
    wait_valid(n);
    checks++; if (n != 34) begin failures++; $display("FAIL b2b_spacing got=%0d exp=34", n); end
    checks++; if (pe_res_o !== 32'hFFFFFFF0) begin failures++; $display("FAIL b2b_q got=%h exp=fffffff0", pe_res_o); end
    checks++; if (rem_q_o !== 32'd2) begin failures++; $display("FAIL b2b_r got=%h exp=00000002", rem_q_o); end
  endtask

  task automatic test_delay_line;
    logic [31:0] exp_d;
    do_reset;
    delay_sel_i = 2'd3; delay_len_i = 3'd3; src_valid_i = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      src_i[31:0] = 32'(i);
      tick;
      exp_d = (i >= 3) ? 32'(i - 2) : 32'd0;
      checks++; if (delay_op_o !== exp_d || delay_op_valid_o !== (i >= 3)) begin
        failures++; $display("FAIL dly_len3 push=%0d got=%h/%h exp=%h", i, delay_op_o, delay_op_valid_o, exp_d); end
    end
    delay_len_i = 3'd0; #1;
    checks++; if (delay_op_o !== 32'd8) begin failures++; $display("FAIL dly_len0 got=%h exp=8", delay_op_o); end
    delay_len_i = 3'd7; #1;
    checks++; if (delay_op_o !== 32'd5) begin failures++; $display("FAIL dly_len7 got=%h exp=5", delay_op_o); end
    delay_len_i = 3'd2; #1;
    checks++; if (delay_op_o !== 32'd7) begin failures++; $display("FAIL dly_len2 got=%h exp=7", delay_op_o); end
    delay_sel_i = 2'd1; delay_len_i = 3'd1; sel_b_i = 2'd2; src_i[95:64] = 32'h77; src_valid_i = 4'b0100;
    tick;
    checks++; if (delay_op_o !== 32'h77 || delay_op_valid_o !== 1'b1) begin
      failures++; $display("FAIL dly_opb got=%h/%h exp=77/1", delay_op_o, delay_op_valid_o); end
    delay_sel_i = 2'd0; sel_a_i = 2'd3; src_i[127:96] = 32'h99;
    tick;
    checks++; if (delay_op_o !== 32'h99 || delay_op_valid_o !== 1'b0) begin
      failures++; $display("FAIL dly_opa got=%h/%h exp=99/0", delay_op_o, delay_op_valid_o); end
  endtask

  task automatic test_abort(input bit use_nop);
    int n;
    do_reset;
    launch(3'd1, 32'd100, 32'd7);
    wait_valid(n);
    tick;
    for (int c = 0; c < 11; c++) tick;
    checks++; if (ready_o !== 1'b0 || pe_res_o !== 32'd14 || rem_q_o !== 32'd2) begin
      failures++; $display("FAIL abort_pre nop=%0d got=%h/%h/%h exp=0/e/2", use_nop, ready_o, pe_res_o, rem_q_o); end
    if (use_nop) op_i = 3'd0;
    else rst_i = 1'b1;
    tick;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      failures++; $display("FAIL abort_state nop=%0d got=%h/%h exp=1/0", use_nop, ready_o, valid_o); end
    checks++; if (pe_res_o !== 32'd0 || rem_q_o !== 32'd0) begin
      failures++; $display("FAIL abort_out nop=%0d got=%h/%h exp=0/0", use_nop, pe_res_o, rem_q_o); end
    rst_i = 1'b0; op_i = 3'd0;
  endtask

  initial begin
    test_reset;
    test_div_timing;
    test_signed_rem;
    test_divu;
    test_div_zero;
    test_overflow;
    test_backpressure;
    test_back_to_back;
    test_delay_line;
    test_abort(1'b0);
    test_abort(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/s_xdiv_pe.md
Name: s_xdiv_pe

Overview:
- Parametrised successor of the streaming divider PE for Mage's PEA in streaming mode.
- Selects two operands from N_SRC neighbour streams and runs signed or unsigned division in a self-contained iterative divider (one quotient bit per cycle).
- Returns quotient or remainder, with the complementary value on a side output.
- Has a programmable-length delay line (1..DELAY_DEPTH stages) instead of a fixed 1/2-stage delay.

Parameters:
- N_BITS, 32, datapath width (>=4)
- N_SRC, 4, number of selectable operand streams
- DELAY_DEPTH, 4, maximum delay-line stages (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- op_i  in  3  0 NOP, 1 DIV, 2 REM, 3 DIVU, 4 REMU; others behave as NOP
- sel_a_i  in  $clog2(N_SRC)  dividend source select
- sel_b_i  in  $clog2(N_SRC)  divisor source select
- delay_sel_i  in  2  delay input: 0 op_a, 1 op_b, 2 rem_q_o, 3 src_i[0]
- delay_len_i  in  $clog2(DELAY_DEPTH)+1  tap 1..DELAY_DEPTH; 0 treated as 1, >DELAY_DEPTH clamped
- src_i  in  N_SRC*N_BITS  neighbour operand data
- src_valid_i  in  N_SRC  neighbour operand valids
- pea_ready_i  in  1  array-wide downstream ready/advance
- ready_o  out  1  divider can accept operands
- valid_o  out  1  pe_res_o valid
- pe_res_o  out  N_BITS  primary result (quotient for DIV/DIVU, remainder for REM/REMU)
- rem_q_o  out  N_BITS  complementary result
- delay_op_o  out  N_BITS  delay-line tap data
- delay_op_valid_o  out  1  delay-line tap valid

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state IDLE; ready_o=1, valid_o=0, pe_res_o=0, rem_q_o=0; all delay stages data 0 and valid 0. Reset mid-CALC aborts the operation with no output.
- Operand selection: op_a=src_i[sel_a_i], op_b=src_i[sel_b_i]. ops_valid = src_valid_i[sel_a_i] & src_valid_i[sel_b_i].
- FSM states: IDLE, CALC, DONE.
- ready_o = (state==IDLE), combinational.
- IDLE: on ops_valid & op in 1..4, latch the operation plus |a| and |b| (signed ops) or raw a and b (unsigned ops), along with the result signs.
  - Divisor nonzero: go to CALC, count=0.
  - Divisor zero: go directly to DONE with quotient all-ones and remainder = a.
- CALC: one restoring step per cycle (shift partial remainder left, bring in next dividend MSB, subtract divisor if no borrow, set quotient bit).
  - After the step with count==N_BITS-1, go to DONE.
  - On that transition apply sign fixup: quotient negated if sign(a)^sign(b); remainder takes sign of a.
  - Signed overflow (a=MIN, b=-1) yields quotient MIN, remainder 0 (falls out of the fixup; must be verified).
- DONE: pe_res_o and rem_q_o are registered on entry, and valid_o=1 while in DONE. If pea_ready_i=1, go to IDLE; valid_o drops the next cycle and pe_res_o holds its last value. If pea_ready_i=0, DONE and both outputs hold.
- Latency, nonzero divisor: accept edge at cycle 0, CALC occupies N_BITS cycles, valid_o high from cycle N_BITS+1. Throughput is one result per N_BITS+2 cycles without backpressure.
- Latency, zero divisor: valid_o high at cycle 1.
- NOP or illegal op_i, in any state: next edge forces IDLE, valid_o=0, pe_res_o=0, rem_q_o=0. The delay line is unaffected.
- op_i changes in CALC/DONE: ignored (operation latched at accept), except change to NOP.
- Back-to-back: in DONE with pea_ready_i=1 the FSM returns to IDLE; a new accept is possible the following cycle, with no same-cycle accept.
- Delay line:
  - Shifts only on cycles with pea_ready_i=1: stage0 <= selected input, stage k <= stage k-1.
  - Input valid: op_a/op_b use their src valids; rem_q_o uses valid_o; src_i[0] uses src_valid_i[0].
  - delay_op_o and delay_op_valid_o = stage[delay_len-1].
  - Changing delay_len_i retaps immediately without flushing.

Test Plan:
- Signed DIV, N_BITS=32, a=100, b=7, pea_ready_i=1 -> ready_o low cycles 1..33; valid_o=1 at cycle 33 only; pe_res_o=14, rem_q_o=2.
- Signed REM, a=-100, b=7 -> pe_res_o=0xFFFFFFFE (-2), rem_q_o=0xFFFFFFF2 (-14). DIVU with a=0xFFFFFFFF, b=2 -> pe_res_o=0x7FFFFFFF, rem_q_o=1.
- Divide by zero, a=5, b=0, DIV -> valid_o=1 at cycle 1; pe_res_o=0xFFFFFFFF, rem_q_o=5. Overflow, a=0x80000000, b=0xFFFFFFFF, DIV -> pe_res_o=0x80000000, rem_q_o=0.
- Backpressure: pea_ready_i=0 for 3 cycles after valid_o rises -> valid_o and pe_res_o held all 3 cycles; ready_o=0; the delay line does not shift; IDLE one cycle after pea_ready_i returns to 1.
- Delay line: delay_sel_i=3, delay_len_i=3, src_i[0] ramps 1,2,3,... with valid -> delay_op_o equals the value pushed 3 advancing edges earlier. Setting delay_len_i=0 behaves as 1; setting delay_len_i=7 with DELAY_DEPTH=4 taps stage 3.
- Abort: rst_i=1 at CALC count 10 -> next cycle IDLE, ready_o=1, valid_o=0, outputs 0. Switching op_i to NOP at count 10 gives the same result.
